// File: rtl/dm_responder.sv
// Single-port word memory responder: captures one request, waits WAIT_CYCLES, then acks for one cycle.
// Optional macro DM_ALIGN_CHECK_EN rejects misaligned accesses with err=1 and no memory effect.
module dm_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_LOG2  = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    // state | meaning
    // IDLE  | waiting for req; captures we/addr/wdata when req=1
    // WAIT  | down-counter running; leaves when counter reads 0
    // RESP  | one-cycle ack (and err/rdata) toward the initiator
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q;
    logic                    we_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic                    mis_q;
    logic [31:0]             wdata_q;

    logic [31:0]             mem [DEPTH];

    logic                    capture;
    logic [DEPTH_LOG2-1:0]   addr_idx;
    logic                    addr_mis;
    logic                    enter_resp;
    logic                    wr_we;
    logic                    wr_mis;
    logic [DEPTH_LOG2-1:0]   wr_idx;
    logic [31:0]             wr_data;
    logic                    wr_en;
    logic                    unused_addr;

    assign addr_idx = addr[DEPTH_LOG2+1:2];

`ifdef DM_ALIGN_CHECK_EN
    assign addr_mis    = (addr[1:0] != 2'b00);
    assign unused_addr = ^{addr[31:DEPTH_LOG2+2]};
`else
    assign addr_mis    = 1'b0;
    assign unused_addr = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};
`endif

    assign capture = (state_q == IDLE) && req;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req) state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
            WAIT: if (cnt_q == 4'd0) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            mis_q   <= 1'b0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                we_q    <= we;
                idx_q   <= addr_idx;
                mis_q   <= addr_mis;
                wdata_q <= wdata;
                cnt_q   <= CNT_LOAD;
            end else if (state_q == WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    // With zero wait states RESP is entered straight from IDLE, so the live inputs are the request.
    assign enter_resp = (state_d == RESP) && (state_q != RESP);
    assign wr_we      = (state_q == IDLE) ? we       : we_q;
    assign wr_mis     = (state_q == IDLE) ? addr_mis : mis_q;
    assign wr_idx     = (state_q == IDLE) ? addr_idx : idx_q;
    assign wr_data    = (state_q == IDLE) ? wdata    : wdata_q;
    assign wr_en      = enter_resp && wr_we && !wr_mis && !reset;

    // Memory is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    assign busy  = (state_q != IDLE);
    assign ack   = (state_q == RESP);
    assign err   = ack && mis_q;
    assign rdata = (ack && !we_q && !mis_q) ? mem[idx_q] : 32'd0;

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder: one instance with 2 wait states, one with none.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we, ack, err, busy;
    logic [31:0] addr, wdata, rdata;
    logic        req0, we0, ack0, err0, busy0;
    logic [31:0] addr0, wdata0, rdata0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_responder #(.WAIT_CYCLES(2), .DEPTH_LOG2(6)) u2 (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .err(err), .busy(busy)
    );

    dm_responder #(.WAIT_CYCLES(0), .DEPTH_LOG2(6)) u0 (
        .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Runs one access on instance sel (0: no wait states, otherwise 2 wait states).
    // edges = number of rising edges from capture to the edge that samples ack high.
    task automatic access(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic e, output int edges, output int bcyc);
        int n;
        if (sel == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        else          begin req  = 1'b1; we  = w; addr  = a; wdata  = d; end
        @(posedge clk); #1;
        if (sel == 0) req0 = 1'b0; else req = 1'b0;
        n = 0;
        bcyc = 0;
        while (!((sel == 0) ? ack0 : ack) && n < 20) begin
            if ((sel == 0) ? busy0 : busy) bcyc++;
            @(posedge clk); #1;
            n++;
        end
        if ((sel == 0) ? busy0 : busy) bcyc++;
        rd    = (sel == 0) ? rdata0 : rdata;
        e     = (sel == 0) ? err0 : err;
        edges = n + 1;
        @(posedge clk); #1;
        chk1("ack_single_pulse", (sel == 0) ? ack0 : ack, 1'b0);
        chk1("err_low_without_ack", (sel == 0) ? err0 : err, 1'b0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          edges, bcyc;
        logic [11:0] v12;
        logic [9:0]  v10;
        logic [5:0]  v6;
        logic [31:0] rd_a, rd_b;

        reset = 1'b1;
        req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk1("reset_ack", ack, 1'b0);
        chk1("reset_err", err, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chk("reset_rdata", rdata, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        access(2, 1'b1, 32'h10, 32'h2A, rd, e, edges, bcyc);
        chk("store_latency_edges", edges, 32'd3);
        chk("store_busy_cycles", bcyc, 32'd3);
        chk1("store_err", e, 1'b0);
        chk("store_rdata_zero", rd, 32'd0);

        access(2, 1'b0, 32'h10, 32'h0, rd, e, edges, bcyc);
        chk("load_0x10", rd, 32'h2A);
        chk("load_latency_edges", edges, 32'd3);
        chk1("load_err", e, 1'b0);

        access(2, 1'b0, 32'h110, 32'h0, rd, e, edges, bcyc);
        chk("load_wrap_0x110", rd, 32'h2A);

        access(2, 1'b1, 32'h1FC, 32'hCAFEF00D, rd, e, edges, bcyc);
        access(2, 1'b0, 32'hFC, 32'h0, rd, e, edges, bcyc);
        chk("load_top_word_wrap", rd, 32'hCAFEF00D);

        access(2, 1'b1, 32'h20, 32'h55, rd, e, edges, bcyc);
        access(2, 1'b0, 32'h20, 32'h0, rd, e, edges, bcyc);
        chk("load_after_store_0x20", rd, 32'h55);

        // req held high: captures at edges 0 and 4, acks sampled after edges 2 and 6
        req = 1'b1; we = 1'b0; addr = 32'h10;
        v12 = '0; rd_a = '0; rd_b = '0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            v12[i] = ack;
            if (i == 2) rd_a = rdata;
            if (i == 6) rd_b = rdata;
            if (i == 7) req = 1'b0;
        end
        chk("hold_req_ack_pattern", 32'(v12), 32'h044);
        chk("hold_req_rdata_first", rd_a, 32'h2A);
        chk("hold_req_rdata_second", rd_b, 32'h2A);

        // req kept high while busy must not queue a second access
        req = 1'b1; we = 1'b0; addr = 32'h10;
        v10 = '0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            v10[i] = ack;
            if (i == 2) req = 1'b0;
        end
        chk("busy_req_ignored", 32'(v10), 32'h004);

        // reset during WAIT aborts the store
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h99;
        @(posedge clk); #1;
        req = 1'b0;
        chk1("pre_abort_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk1("abort_busy", busy, 1'b0);
        v6 = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            v6[i] = ack | err | (rdata != 32'd0);
        end
        chk("abort_no_ack", 32'(v6), 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        access(2, 1'b0, 32'h20, 32'h0, rd, e, edges, bcyc);
        chk("abort_old_value", rd, 32'h55);
        access(2, 1'b0, 32'h10, 32'h0, rd, e, edges, bcyc);
        chk("mem_kept_over_reset", rd, 32'h2A);

        access(2, 1'b1, 32'h22, 32'hDEADBEEF, rd, e, edges, bcyc);
        chk("misaligned_latency", edges, 32'd3);
        chk("misaligned_rdata", rd, 32'd0);
`ifdef DM_ALIGN_CHECK_EN
        chk1("misaligned_err", e, 1'b1);
        access(2, 1'b0, 32'h20, 32'h0, rd, e, edges, bcyc);
        chk("misaligned_no_write", rd, 32'h55);
`else
        chk1("misaligned_err", e, 1'b0);
        access(2, 1'b0, 32'h20, 32'h0, rd, e, edges, bcyc);
        chk("misaligned_writes_word", rd, 32'hDEADBEEF);
`endif
        chk1("aligned_load_err", e, 1'b0);

        access(0, 1'b1, 32'h4, 32'h1234, rd, e, edges, bcyc);
        chk("w0_store_latency", edges, 32'd1);
        chk("w0_store_busy", bcyc, 32'd1);
        access(0, 1'b0, 32'h4, 32'h0, rd, e, edges, bcyc);
        chk("w0_load_latency", edges, 32'd1);
        chk("w0_load_data", rd, 32'h1234);

        // zero wait states, req held: ack every other cycle
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h4;
        v6 = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            v6[i] = ack0;
            if (i == 4) req0 = 1'b0;
        end
        chk("w0_back_to_back", 32'(v6), 32'h15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
